arb_client: RTL and testbench

- Requester-side endpoint of the lock-semantics arbiter. One instance per machine.
- Accepts a job, raises its request line, and waits for its grant bit.
- While holding the grant, issues one bus beat per address to the shared resource, then drops the request to release the lock.
- Its `req_out` drives one bit of the arbiter's `reqs_in`; its `gnt_in` is the matching bit of the arbiter's `gnt_out`.

---
 rtl/arb_client.sv | 176 +++++++++++++++++
 tb/tb_arb_client.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/arb_client.sv
// Requester-side endpoint of the lock-semantics arbiter: accepts one job, holds the lock, issues one beat per address.
// Optional ARB_CLIENT_LOCK_HOLD_LIMIT_EN caps beats per grant at HOLD_MAX and yields the lock between bursts.
module arb_client #(
    parameter int ADDR_W   = 32,
    parameter int LEN_W    = 8,
    parameter int HOLD_MAX = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              job_valid,
    input  logic [ADDR_W-1:0] job_addr,
    input  logic [LEN_W-1:0]  job_len,
    output logic              job_ready,
    output logic              req_out,
    input  logic              gnt_in,
    output logic              bus_valid,
    output logic [ADDR_W-1:0] bus_addr,
    input  logic              bus_ready,
    output logic              done_out,
    output logic              busy_out
);

`ifdef ARB_CLIENT_LOCK_HOLD_LIMIT_EN
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_XFER    = 3'd2,
        S_RELEASE = 3'd3,
        S_YIELD   = 3'd4
    } state_t;

    localparam int HOLD_W = $clog2(HOLD_MAX + 1);
    logic [HOLD_W-1:0] hold_q, hold_nxt;
    logic              hold_full;
`else
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_XFER    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;
`endif

    generate
        if (HOLD_MAX < 1) begin : g_bad_hold_max
            $error("arb_client: HOLD_MAX must be at least 1");
        end
    endgenerate

    state_t            state, state_nxt;
    logic              req_q, req_nxt;
    logic              done_q, done_nxt;
    logic [ADDR_W-1:0] base_q, base_nxt;
    logic [LEN_W-1:0]  len_q, len_nxt;
    logic [LEN_W-1:0]  beat_q, beat_nxt;
    logic              last_beat;

    assign last_beat = (beat_q == (len_q - LEN_W'(1)));
    // Address wraps modulo 2^ADDR_W by plain truncating addition.
    assign bus_addr  = base_q + ADDR_W'(beat_q);
    assign req_out   = req_q;
    assign done_out  = done_q;
    assign busy_out  = (state != S_IDLE);

`ifdef ARB_CLIENT_LOCK_HOLD_LIMIT_EN
    assign hold_full = (hold_q == HOLD_W'(HOLD_MAX - 1));
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= S_IDLE;
            req_q  <= 1'b0;
            done_q <= 1'b0;
            base_q <= '0;
            len_q  <= '0;
            beat_q <= '0;
`ifdef ARB_CLIENT_LOCK_HOLD_LIMIT_EN
            hold_q <= '0;
`endif
        end else begin
            state  <= state_nxt;
            req_q  <= req_nxt;
            done_q <= done_nxt;
            base_q <= base_nxt;
            len_q  <= len_nxt;
            beat_q <= beat_nxt;
`ifdef ARB_CLIENT_LOCK_HOLD_LIMIT_EN
            hold_q <= hold_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        req_nxt   = req_q;
        done_nxt  = 1'b0;
        base_nxt  = base_q;
        len_nxt   = len_q;
        beat_nxt  = beat_q;
        job_ready = 1'b0;
        bus_valid = 1'b0;
`ifdef ARB_CLIENT_LOCK_HOLD_LIMIT_EN
        hold_nxt  = hold_q;
`endif
        case (state)
            S_IDLE: begin
                job_ready = 1'b1;
                if (job_valid) begin
                    base_nxt = job_addr;
                    len_nxt  = job_len;
                    beat_nxt = '0;
                    if (job_len != '0) begin
                        state_nxt = S_REQ;
                        req_nxt   = 1'b1;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end
            S_REQ: begin
                req_nxt = 1'b1;
                if (gnt_in) begin
                    state_nxt = S_XFER;
`ifdef ARB_CLIENT_LOCK_HOLD_LIMIT_EN
                    hold_nxt  = '0;
`endif
                end
            end
            S_XFER: begin
                // Lost grant: beat count is kept so the job resumes where it stopped.
                bus_valid = gnt_in;
                if (!gnt_in) begin
                    state_nxt = S_REQ;
                    req_nxt   = 1'b1;
                end else if (bus_ready) begin
                    beat_nxt = beat_q + LEN_W'(1);
`ifdef ARB_CLIENT_LOCK_HOLD_LIMIT_EN
                    hold_nxt = hold_q + HOLD_W'(1);
`endif
                    if (last_beat) begin
                        state_nxt = S_RELEASE;
                        req_nxt   = 1'b0;
                    end
`ifdef ARB_CLIENT_LOCK_HOLD_LIMIT_EN
                    else if (hold_full) begin
                        state_nxt = S_YIELD;
                        req_nxt   = 1'b0;
                    end
`endif
                end
            end
            S_RELEASE: begin
                // Wait for the grant to clear so the arbiter never sees a stale req&gnt.
                req_nxt = 1'b0;
                if (!gnt_in) begin
                    state_nxt = S_IDLE;
                    done_nxt  = 1'b1;
                end
            end
`ifdef ARB_CLIENT_LOCK_HOLD_LIMIT_EN
            S_YIELD: begin
                req_nxt = 1'b0;
                if (!gnt_in) begin
                    state_nxt = S_REQ;
                    req_nxt   = 1'b1;
                end
            end
`endif
            default: begin
                state_nxt = S_IDLE;
                req_nxt   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_arb_client.sv
// Directed bench for arb_client with a registered single-requester arbiter model.
module tb_arb_client;
    localparam int ADDR_W = 32;
    localparam int LEN_W  = 8;

    logic              clock = 1'b0;
    logic              reset;
    logic              job_valid;
    logic [ADDR_W-1:0] job_addr;
    logic [LEN_W-1:0]  job_len;
    logic              job_ready;
    logic              req_out;
    logic              gnt_in;
    logic              bus_valid;
    logic [ADDR_W-1:0] bus_addr;
    logic              bus_ready;
    logic              done_out;
    logic              busy_out;

    logic              gnt_en;
    int                n_cmp = 0;
    int                n_err = 0;

    logic [ADDR_W-1:0] beats [$];
    int                tenure_beats [$];
    int                done_cnt = 0;
    int                stale_req = 0;
    logic              req_prev = 1'b0;
    logic              gnt_prev = 1'b0;
    logic [ADDR_W-1:0] exp_wrap [4] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};

    arb_client #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .HOLD_MAX(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .job_valid (job_valid),
        .job_addr  (job_addr),
        .job_len   (job_len),
        .job_ready (job_ready),
        .req_out   (req_out),
        .gnt_in    (gnt_in),
        .bus_valid (bus_valid),
        .bus_addr  (bus_addr),
        .bus_ready (bus_ready),
        .done_out  (done_out),
        .busy_out  (busy_out)
    );

    always #5 clock = ~clock;

    // Registered arbiter: grant follows request one cycle later.
    always @(posedge clock) begin
        if (reset) gnt_in <= 1'b0;
        else       gnt_in <= req_out && gnt_en;
    end

    always @(posedge clock) begin
        if (!reset) begin
            if (req_out && !req_prev) begin
                tenure_beats.push_back(0);
                if (gnt_prev) stale_req++;
            end
            if (bus_valid && bus_ready) begin
                beats.push_back(bus_addr);
                if (tenure_beats.size() > 0)
                    tenure_beats[tenure_beats.size()-1] += 1;
            end
            if (done_out) done_cnt++;
        end
        req_prev = reset ? 1'b0 : req_out;
        gnt_prev = gnt_in;
    end

    task automatic start_job(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l);
        job_valid = 1'b1;
        job_addr  = a;
        job_len   = l;
        @(negedge clock);
        job_valid = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget, input string name);
        int i;
        for (i = 0; i < budget && done_cnt == d0; i++) @(negedge clock);
        n_cmp++;
        if (done_cnt == d0) begin
            n_err++;
            $display("FAIL %s_timeout: no done_out within %0d cycles", name, budget);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; job_valid = 1'b0; job_addr = '0; job_len = '0;
        bus_ready = 1'b0; gnt_en = 1'b1;
        repeat (3) @(negedge clock);
        n_cmp++; if (job_ready !== 1'b1) begin n_err++; $display("FAIL rst_job_ready: got %b want 1", job_ready); end
        n_cmp++; if (req_out !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b want 0", req_out); end
        n_cmp++; if (bus_valid !== 1'b0) begin n_err++; $display("FAIL rst_bus_valid: got %b want 0", bus_valid); end
        n_cmp++; if (bus_addr !== 32'h0) begin n_err++; $display("FAIL rst_bus_addr: got %h want 0", bus_addr); end
        n_cmp++; if (done_out !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b want 0", done_out); end
        n_cmp++; if (busy_out !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy_out); end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_basic;
        logic [ADDR_W-1:0] exp_a [3] = '{32'h100, 32'h101, 32'h102};
        bus_ready = 1'b1; gnt_en = 1'b1;
        start_job(32'h100, 8'd3);
        n_cmp++; if (req_out !== 1'b1) begin n_err++; $display("FAIL basic_req_rise: got %b want 1", req_out); end
        n_cmp++; if (job_ready !== 1'b0) begin n_err++; $display("FAIL basic_job_ready_busy: got %b want 0", job_ready); end
        n_cmp++; if (busy_out !== 1'b1) begin n_err++; $display("FAIL basic_busy: got %b want 1", busy_out); end
        @(negedge clock);
        n_cmp++; if (bus_valid !== 1'b0) begin n_err++; $display("FAIL basic_no_early_beat: got %b want 0", bus_valid); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            n_cmp++;
            if ({bus_valid, bus_addr} !== {1'b1, exp_a[k]}) begin
                n_err++; $display("FAIL basic_beat%0d: got valid=%b addr=%h want valid=1 addr=%h", k, bus_valid, bus_addr, exp_a[k]);
            end
        end
        @(negedge clock);
        n_cmp++; if ({req_out, bus_valid} !== 2'b00) begin n_err++; $display("FAIL basic_release: got req=%b valid=%b want 0 0", req_out, bus_valid); end
        @(negedge clock);
        n_cmp++; if ({done_out, busy_out} !== 2'b01) begin n_err++; $display("FAIL basic_release_wait: got done=%b busy=%b want 0 1", done_out, busy_out); end
        @(negedge clock);
        n_cmp++; if ({done_out, job_ready, busy_out} !== 3'b110) begin n_err++; $display("FAIL basic_done: got done=%b ready=%b busy=%b want 1 1 0", done_out, job_ready, busy_out); end
        @(negedge clock);
        n_cmp++; if (done_out !== 1'b0) begin n_err++; $display("FAIL basic_done_pulse: got %b want 0", done_out); end
    endtask

    task automatic test_len_zero;
        int d0 = done_cnt;
        start_job(32'h55, 8'd0);
        n_cmp++; if ({done_out, req_out, job_ready} !== 3'b101) begin n_err++; $display("FAIL len0_done: got done=%b req=%b ready=%b want 1 0 1", done_out, req_out, job_ready); end
        @(negedge clock);
        n_cmp++; if ({done_out, req_out} !== 2'b00) begin n_err++; $display("FAIL len0_after: got done=%b req=%b want 0 0", done_out, req_out); end
        n_cmp++; if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL len0_count: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_wrap;
        int d0 = done_cnt;
        beats.delete();
        start_job(32'hFFFF_FFFE, 8'd4);
        wait_done(d0, 40, "wrap");
        repeat (3) @(negedge clock);
        n_cmp++; if (beats.size() !== 4) begin n_err++; $display("FAIL wrap_count: got %0d want 4", beats.size()); end
        for (int k = 0; k < 4 && k < beats.size(); k++) begin
            n_cmp++;
            if (beats[k] !== exp_wrap[k]) begin n_err++; $display("FAIL wrap_addr%0d: got %h want %h", k, beats[k], exp_wrap[k]); end
        end
        n_cmp++; if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL wrap_done_count: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_withhold;
        int d0 = done_cnt;
        logic [ADDR_W-1:0] exp_a [3] = '{32'h200, 32'h201, 32'h202};
        beats.delete();
        gnt_en = 1'b0; bus_ready = 1'b1;
        start_job(32'h200, 8'd3);
        for (int k = 0; k < 5; k++) begin
            bus_ready = ~bus_ready;
            @(negedge clock);
            n_cmp++; if (bus_valid !== 1'b0) begin n_err++; $display("FAIL hold_no_valid%0d: got %b want 0", k, bus_valid); end
        end
        gnt_en = 1'b1;
        for (int k = 0; k < 60 && done_cnt == d0; k++) begin
            bus_ready = ~bus_ready;
            @(negedge clock);
        end
        n_cmp++; if (done_cnt == d0) begin n_err++; $display("FAIL hold_timeout: got no done want done"); end
        bus_ready = 1'b1;
        n_cmp++; if (beats.size() !== 3) begin n_err++; $display("FAIL hold_count: got %0d want 3", beats.size()); end
        for (int k = 0; k < 3 && k < beats.size(); k++) begin
            n_cmp++;
            if (beats[k] !== exp_a[k]) begin n_err++; $display("FAIL hold_addr%0d: got %h want %h", k, beats[k], exp_a[k]); end
        end
    endtask

    task automatic test_reset_mid;
        int d0 = done_cnt;
        int k;
        beats.delete();
        gnt_en = 1'b1; bus_ready = 1'b1;
        start_job(32'h300, 8'd6);
        for (k = 0; k < 20 && beats.size() < 2; k++) @(negedge clock);
        n_cmp++; if (beats.size() !== 2) begin n_err++; $display("FAIL rmid_two_beats: got %0d want 2", beats.size()); end
        reset = 1'b1;
        @(negedge clock);
        n_cmp++;
        if ({req_out, bus_valid, job_ready, busy_out} !== 4'b0010) begin
            n_err++; $display("FAIL rmid_state: got req=%b valid=%b ready=%b busy=%b want 0 0 1 0", req_out, bus_valid, job_ready, busy_out);
        end
        reset = 1'b0;
        repeat (8) @(negedge clock);
        n_cmp++; if (done_cnt !== d0) begin n_err++; $display("FAIL rmid_no_done: got %0d pulses want 0", done_cnt - d0); end
        n_cmp++; if (req_out !== 1'b0) begin n_err++; $display("FAIL rmid_idle_req: got %b want 0", req_out); end
    endtask

    task automatic test_long_job;
        int d0 = done_cnt;
        beats.delete(); tenure_beats.delete(); stale_req = 0;
        gnt_en = 1'b1; bus_ready = 1'b1;
        start_job(32'h400, 8'd10);
        wait_done(d0, 150, "long");
        repeat (3) @(negedge clock);
        n_cmp++; if (beats.size() !== 10) begin n_err++; $display("FAIL long_count: got %0d want 10", beats.size()); end
        for (int k = 0; k < 10 && k < beats.size(); k++) begin
            n_cmp++;
            if (beats[k] !== 32'h400 + k) begin n_err++; $display("FAIL long_addr%0d: got %h want %h", k, beats[k], 32'h400 + k); end
        end
        n_cmp++; if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL long_done_count: got %0d want 1", done_cnt - d0); end
        n_cmp++; if (stale_req !== 0) begin n_err++; $display("FAIL long_stale_req: got %0d want 0", stale_req); end
`ifdef ARB_CLIENT_LOCK_HOLD_LIMIT_EN
        n_cmp++;
        if (tenure_beats.size() !== 3) begin
            n_err++; $display("FAIL long_tenures: got %0d want 3", tenure_beats.size());
        end else if (tenure_beats[0] !== 4 || tenure_beats[1] !== 4 || tenure_beats[2] !== 2) begin
            n_err++; $display("FAIL long_tenure_beats: got %0d,%0d,%0d want 4,4,2", tenure_beats[0], tenure_beats[1], tenure_beats[2]);
        end
`else
        n_cmp++;
        if (tenure_beats.size() !== 1) begin
            n_err++; $display("FAIL long_tenures: got %0d want 1", tenure_beats.size());
        end else if (tenure_beats[0] !== 10) begin
            n_err++; $display("FAIL long_tenure_beats: got %0d want 10", tenure_beats[0]);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_len_zero();
        test_wrap();
        test_withhold();
        test_reset_mid();
        test_long_job();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
